// File: rtl/scan_sequencer.sv
// Scan sequencer for a 2-to-4 decoder. It steps the index 0..3 with a blanked lead-in on every slot.
// Define SCAN_SEQ_STEP_EN to add the manual single-step input `step`.
module scan_sequencer #(
    parameter int DIV   = 4,
    parameter int BLANK = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
`ifdef SCAN_SEQ_STEP_EN
    input  logic step,
`endif
    output logic a,
    output logic b,
    output logic en,
    output logic wrap
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_BLANKING = 2'd1;
    localparam logic [1:0] S_ACTIVE   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          en_q, wrap_q, wrap_d;
    logic          stay_slot;
    logic          single_now;
    logic          step_rise;
    logic [DIV-1:0] blank_mask;

    // Slot positions that keep the decoder disabled.
    for (genvar gi = 0; gi < DIV; gi++) begin : g_blank
        assign blank_mask[gi] = (gi < BLANK);
    end

`ifdef SCAN_SEQ_STEP_EN
    logic step_q;
    logic single_q, single_d;
    assign step_rise  = step & ~step_q;
    assign single_now = single_q;
`else
    assign step_rise  = 1'b0;
    assign single_now = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        wrap_d    = 1'b0;
        stay_slot = 1'b0;
`ifdef SCAN_SEQ_STEP_EN
        single_d  = single_q;
`endif
        if (state_q == S_IDLE) begin
            cnt_d = '0;
            if (run) begin
                stay_slot = 1'b1;
`ifdef SCAN_SEQ_STEP_EN
                single_d  = 1'b0;
`endif
            end else if (step_rise) begin
                // A manual step advances first, then shows exactly one slot.
                idx_d     = idx_q + 2'd1;
                wrap_d    = (idx_q == 2'd3);
                stay_slot = 1'b1;
`ifdef SCAN_SEQ_STEP_EN
                single_d  = 1'b1;
`endif
            end
        end else if (!run && !single_now) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
`ifdef SCAN_SEQ_STEP_EN
            if (run) single_d = 1'b0;
`endif
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                if (single_now && !run) begin
                    state_d = S_IDLE;
`ifdef SCAN_SEQ_STEP_EN
                    single_d = 1'b0;
`endif
                end else begin
                    idx_d     = idx_q + 2'd1;
                    wrap_d    = (idx_q == 2'd3);
                    stay_slot = 1'b1;
                end
            end else begin
                cnt_d     = cnt_q + 1'b1;
                stay_slot = 1'b1;
            end
        end
        if (stay_slot) begin
            state_d = blank_mask[cnt_d] ? S_BLANKING : S_ACTIVE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            en_q    <= (state_d == S_ACTIVE);
            wrap_q  <= wrap_d;
        end
    end

`ifdef SCAN_SEQ_STEP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            step_q   <= 1'b0;
            single_q <= 1'b0;
        end else begin
            step_q   <= step;
            single_q <= single_d;
        end
    end
`endif

    assign a    = idx_q[0];
    assign b    = idx_q[1];
    assign en   = en_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Randomised bench for scan_sequencer: three parameterisations checked each cycle against a slot-level model.
// Directed sections pin reset, free-run pattern, run drop/restart, mid-slot reset and manual stepping.
module tb_scan_sequencer;

    logic clk = 1'b0;
    logic rst, run, step;
    logic [2:0] a_w, b_w, en_w, wrap_w;

    int total = 0;
    int bad   = 0;

    localparam int NI = 3;
    int divs[NI]   = '{4, 2, 5};
    int blanks[NI] = '{1, 0, 2};

`ifdef SCAN_SEQ_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    scan_sequencer #(.DIV(4), .BLANK(1)) dut0 (
        .clk(clk), .rst(rst), .run(run),
`ifdef SCAN_SEQ_STEP_EN
        .step(step),
`endif
        .a(a_w[0]), .b(b_w[0]), .en(en_w[0]), .wrap(wrap_w[0]));

    scan_sequencer #(.DIV(2), .BLANK(0)) dut1 (
        .clk(clk), .rst(rst), .run(run),
`ifdef SCAN_SEQ_STEP_EN
        .step(step),
`endif
        .a(a_w[1]), .b(b_w[1]), .en(en_w[1]), .wrap(wrap_w[1]));

    scan_sequencer #(.DIV(5), .BLANK(2)) dut2 (
        .clk(clk), .rst(rst), .run(run),
`ifdef SCAN_SEQ_STEP_EN
        .step(step),
`endif
        .a(a_w[2]), .b(b_w[2]), .en(en_w[2]), .wrap(wrap_w[2]));

    // Model: whether a slot is showing, whether it is a one-shot manual slot,
    // the index, the position within the slot, and the wrap flag.
    bit m_inslot[NI];
    bit m_single[NI];
    int m_idx[NI];
    int m_pos[NI];
    bit m_wrap[NI];
    bit m_prev_step = 1'b0;

    task automatic chk(input string nm, input int k, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s inst%0d t=%0t got=%0d want=%0d", nm, k, $time, act, exp);
        end
    endtask

    function automatic void advance(input int k);
        m_idx[k]  = (m_idx[k] + 1) % 4;
        m_wrap[k] = (m_idx[k] == 0);
        m_pos[k]  = 0;
    endfunction

    always @(posedge clk) begin
        bit rise;
        rise = STEP_EN && step && !m_prev_step;
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                m_inslot[k] = 0; m_single[k] = 0; m_idx[k] = 0; m_pos[k] = 0; m_wrap[k] = 0;
            end else begin
                m_wrap[k] = 0;
                if (!m_inslot[k]) begin
                    if (run) begin
                        m_inslot[k] = 1; m_single[k] = 0; m_pos[k] = 0;
                    end else if (rise) begin
                        advance(k);
                        m_inslot[k] = 1; m_single[k] = 1;
                    end
                end else if (!run && !m_single[k]) begin
                    m_inslot[k] = 0; m_pos[k] = 0;
                end else begin
                    if (run) m_single[k] = 0;
                    if (m_pos[k] == divs[k] - 1) begin
                        if (m_single[k]) begin
                            m_inslot[k] = 0; m_single[k] = 0; m_pos[k] = 0;
                        end else begin
                            advance(k);
                        end
                    end else begin
                        m_pos[k]++;
                    end
                end
            end
        end
        m_prev_step = rst ? 1'b0 : step;
    end

    always @(negedge clk) begin
        if ($time > 10) begin
            for (int k = 0; k < NI; k++) begin
                chk("model_idx",  k, int'({b_w[k], a_w[k]}), m_idx[k]);
                chk("model_en",   k, int'(en_w[k]), int'(m_inslot[k] && m_pos[k] >= blanks[k]));
                chk("model_wrap", k, int'(wrap_w[k]), int'(m_wrap[k]));
            end
        end
    end

    initial begin
        rst = 1'b1; run = 1'b1; step = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_ab",   0, int'({b_w[0], a_w[0]}), 0);
            chk("rst_en",   0, int'(en_w[0]), 0);
            chk("rst_wrap", 0, int'(wrap_w[0]), 0);
        end
        rst = 1'b0;

        // Free run: 4-cycle slots, en 0111, wrap on first cycle of the second 00 slot.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("run_idx",   0, int'({b_w[0], a_w[0]}), (c / 4) % 4);
            chk("run_en",    0, int'(en_w[0]), int'((c % 4) != 0));
            chk("run_wrap",  0, int'(wrap_w[0]), int'(c == 16));
            chk("b0_en",     1, int'(en_w[1]), 1);
            chk("b0_idx",    1, int'({b_w[1], a_w[1]}), (c / 2) % 4);
        end

        // Drop run at the last cycle of idx 2, then restart.
        repeat (8) @(negedge clk);
        chk("drop_pre_idx", 0, int'({b_w[0], a_w[0]}), 2);
        chk("drop_pre_en",  0, int'(en_w[0]), 1);
        run = 1'b0;
        @(negedge clk);
        chk("drop_en",  0, int'(en_w[0]), 0);
        chk("drop_idx", 0, int'({b_w[0], a_w[0]}), 2);
        repeat (2) @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        chk("restart_idx", 0, int'({b_w[0], a_w[0]}), 2);
        chk("restart_en0", 0, int'(en_w[0]), 0);
        @(negedge clk);
        chk("restart_en1", 0, int'(en_w[0]), 1);

        // Reset mid-ACTIVE at idx 3.
        repeat (3) @(negedge clk);
        chk("i3_idx", 0, int'({b_w[0], a_w[0]}), 3);
        @(negedge clk);
        chk("i3_en", 0, int'(en_w[0]), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ab", 0, int'({b_w[0], a_w[0]}), 0);
        chk("mid_rst_en", 0, int'(en_w[0]), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idx",  0, int'({b_w[0], a_w[0]}), 0);
        chk("post_rst_wrap", 0, int'(wrap_w[0]), 0);
        @(negedge clk);
        chk("post_rst_en", 0, int'(en_w[0]), 1);

`ifdef SCAN_SEQ_STEP_EN
        run = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_idx", 0, int'({b_w[0], a_w[0]}), 0);
        for (int s = 1; s <= 4; s++) begin
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            chk("step_idx",  0, int'({b_w[0], a_w[0]}), s % 4);
            chk("step_en0",  0, int'(en_w[0]), 0);
            chk("step_wrap", 0, int'(wrap_w[0]), int'(s == 4));
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                chk("step_en1", 0, int'(en_w[0]), 1);
            end
            @(negedge clk);
            chk("step_idle_en", 0, int'(en_w[0]), 0);
            repeat (4) @(negedge clk);
            chk("step_hold_idx", 0, int'({b_w[0], a_w[0]}), s % 4);
        end
        step = 1'b1;
        repeat (10) @(negedge clk);
        step = 1'b0;
        repeat (6) @(negedge clk);
        chk("held_step_idx", 0, int'({b_w[0], a_w[0]}), 1);
        chk("held_step_en",  0, int'(en_w[0]), 0);
`endif

        // Randomised run/step/reset traffic; the model compare runs every cycle.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst  = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 15) == 0) run = ~run;
            step = ($urandom_range(0, 5) == 0);
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
